// File: rtl/fifo_pkg.sv
// Shared widths and error-flag payload for the parameterised synchronous FIFO.
package fifo_pkg;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? int'($clog2(depth)) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return int'($clog2(depth)) + 1;
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_flags_t;

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and sticky-error control for a power-of-two FIFO.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic                      clr_err,
    output logic                      wr_en,
    output logic [ptr_w(DEPTH)-1:0]   wr_addr,
    output logic [ptr_w(DEPTH)-1:0]   rd_addr,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output err_flags_t                err
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic [PTR_W-1:0] wr_ptr, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    err_flags_t       err_q, err_d;
    logic             push_ok;
    logic             pop_ok;

    // Status flags are pure decodes of the registered count.
    assign full         = (cnt_q == CNT_W'(DEPTH));
    assign empty        = (cnt_q == '0);
    assign almost_full  = (cnt_q >= CNT_W'(AFULL_TH));
    assign almost_empty = (cnt_q <= CNT_W'(AEMPTY_TH));

    assign count   = cnt_q;
    assign wr_addr = wr_ptr;
    assign rd_addr = rd_ptr;
    assign err     = err_q;

    // Full bypass: a pop on a full FIFO frees the head slot for the same-cycle push.
    always_comb begin
        push_ok  = 1'b0;
        pop_ok   = 1'b0;
        wr_en    = 1'b0;
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        cnt_d    = cnt_q;
        err_d    = err_q;

        if (clr_err) begin
            err_d = '0;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            push_ok = push & (~full | pop);
            pop_ok  = pop & ~empty;
            wr_en   = push_ok & ~rst;

            if (push & ~push_ok) err_d.overflow  = 1'b1;
            if (pop & ~pop_ok)   err_d.underflow = 1'b1;

            if (push_ok) wr_ptr_d = wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr + PTR_W'(1);

            if (push_ok & ~pop_ok)      cnt_d = cnt_q + CNT_W'(1);
            else if (pop_ok & ~push_ok) cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            err_q  <= '0;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// First-word-fall-through synchronous FIFO: storage array around fifo_ctrl.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AFULL_TH   = DEPTH - 2,
    parameter int unsigned AEMPTY_TH  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        flush,
    input  logic                        clr_err,
    input  logic [DATA_WIDTH-1:0]       din,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
    end
    if (AFULL_TH > DEPTH) begin : g_bad_afull
        $error("sync_fifo_param: AFULL_TH must not exceed DEPTH");
    end
    if (AEMPTY_TH >= DEPTH) begin : g_bad_aempty
        $error("sync_fifo_param: AEMPTY_TH must be below DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_en;
    logic [PTR_W-1:0]      wr_addr;
    logic [PTR_W-1:0]      rd_addr;
    err_flags_t            err;

    fifo_ctrl #(
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .flush        (flush),
        .clr_err      (clr_err),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .err          (err)
    );

    // Storage is deliberately unreset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= din;
        end
    end

    assign dout      = mem[rd_addr];
    assign overflow  = err.overflow;
    assign underflow = err.underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed, table-driven check of sync_fifo_param at DEPTH=8, DATA_WIDTH=32.
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        flush = 1'b0;
    logic        clr_err = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        full, empty, almost_full, almost_empty;
    logic [3:0]  count;
    logic        overflow, underflow;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst, push, pop, flush, clr;
        logic [31:0] din;
        int          cnt;
        logic [31:0] dout;
        bit          chkd;
        logic        ov, un;
    } vec_t;

    vec_t vq[$];

    sync_fifo_param #(
        .DATA_WIDTH (32),
        .DEPTH      (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .flush        (flush),
        .clr_err      (clr_err),
        .din          (din),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic p, input logic q, input logic f, input logic c,
                       input logic [31:0] d, input int cnt, input logic [31:0] dd, input bit chkd,
                       input logic ov, input logic un);
        vec_t t;
        t.rst = r; t.push = p; t.pop = q; t.flush = f; t.clr = c;
        t.din = d; t.cnt = cnt; t.dout = dd; t.chkd = chkd; t.ov = ov; t.un = un;
        vq.push_back(t);
    endtask

    // Flag expectations follow directly from the expected count (DEPTH=8, AFULL_TH=6, AEMPTY_TH=2).
    task automatic check_state(input string tag, input int cnt, input logic [31:0] dd, input bit chkd,
                               input logic ov, input logic un);
        chk({tag, " count"}, 32'(count), 32'(cnt));
        chk({tag, " empty"}, 32'(empty), 32'(cnt == 0));
        chk({tag, " full"}, 32'(full), 32'(cnt == 8));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(cnt >= 6));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(cnt <= 2));
        chk({tag, " overflow"}, 32'(overflow), 32'(ov));
        chk({tag, " underflow"}, 32'(underflow), 32'(un));
        if (chkd) chk({tag, " dout"}, dout, dd);
    endtask

    initial begin
        // reset
        add(1,0,0,0,0, 32'h0, 0, 32'h0, 0, 0,0);
        add(1,0,0,0,0, 32'h0, 0, 32'h0, 0, 0,0);
        // fill 0x10..0x17 then drain
        for (int i = 0; i < 8; i++) add(0,1,0,0,0, 32'(32'h10 + i), i + 1, 32'h10, 1, 0,0);
        for (int i = 0; i < 8; i++) add(0,0,1,0,0, 32'h0, 7 - i, 32'(32'h11 + i), i < 7, 0,0);
        // wrap-around: push 5, pop 5, push 8
        for (int i = 0; i < 5; i++) add(0,1,0,0,0, 32'(32'h20 + i), i + 1, 32'h20, 1, 0,0);
        for (int i = 0; i < 5; i++) add(0,0,1,0,0, 32'h0, 4 - i, 32'(32'h21 + i), i < 4, 0,0);
        for (int i = 0; i < 8; i++) add(0,1,0,0,0, 32'(32'h30 + i), i + 1, 32'h30, 1, 0,0);
        // overflow, full bypass, clear
        add(0,1,0,0,0, 32'h99, 8, 32'h30, 1, 1,0);
        add(0,1,1,0,0, 32'hAA, 8, 32'h31, 1, 1,0);
        add(0,0,0,0,1, 32'h0,  8, 32'h31, 1, 0,0);
        for (int i = 0; i < 6; i++) add(0,0,1,0,0, 32'h0, 7 - i, 32'(32'h32 + i), 1, 0,0);
        add(0,0,1,0,0, 32'h0, 1, 32'hAA, 1, 0,0);
        add(0,0,1,0,0, 32'h0, 0, 32'h0, 0, 0,0);
        // underflow on empty, set-wins-over-clear
        add(0,1,1,0,0, 32'h55, 1, 32'h55, 1, 0,1);
        add(0,0,1,0,1, 32'h0,  0, 32'h0, 0, 0,0);
        add(0,0,1,0,1, 32'h0,  0, 32'h0, 0, 0,1);
        add(0,0,0,0,1, 32'h0,  0, 32'h0, 0, 0,0);
        // thresholds and flush
        for (int i = 0; i < 6; i++) add(0,1,0,0,0, 32'(32'h60 + i), i + 1, 32'h60, 1, 0,0);
        add(0,1,0,1,0, 32'h77, 0, 32'h0, 0, 0,0);
        add(0,0,1,1,0, 32'h0,  0, 32'h0, 0, 0,0);
        add(0,0,1,0,0, 32'h0,  0, 32'h0, 0, 0,1);
        add(0,0,0,1,0, 32'h0,  0, 32'h0, 0, 0,1);
        add(0,0,0,0,1, 32'h0,  0, 32'h0, 0, 0,0);
        for (int i = 0; i < 4; i++) add(0,1,0,0,0, 32'(32'h88 + i), i + 1, 32'h88, 1, 0,0);

        foreach (vq[k]) begin
            rst = vq[k].rst; push = vq[k].push; pop = vq[k].pop;
            flush = vq[k].flush; clr_err = vq[k].clr; din = vq[k].din;
            @(posedge clk);
            #1;
            check_state($sformatf("vec%0d", k), vq[k].cnt, vq[k].dout, vq[k].chkd, vq[k].ov, vq[k].un);
        end

        // async reset mid-stream with count=4, checked before the next edge
        push = 1'b0;
        pop = 1'b0;
        #2 rst = 1'b1;
        #1 check_state("async_rst", 0, 32'h0, 0, 0, 0);
        push = 1'b1;
        din = 32'hEE;
        @(posedge clk);
        #1 check_state("rst_hold", 0, 32'h0, 0, 0, 0);
        rst = 1'b0;
        din = 32'hC0;
        @(posedge clk);
        #1 check_state("post_rst", 1, 32'hC0, 1, 0, 0);
        push = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, meaning the payload width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 8, meaning the number of entries; it must be a power of two and at least 2.
REQ-003 The module SHALL have parameter AFULL_TH, default DEPTH-2, meaning almost_full asserts when count >= AFULL_TH.
REQ-004 The module SHALL have parameter AEMPTY_TH, default 2, meaning almost_empty asserts when count <= AEMPTY_TH.
REQ-005 The module SHALL have the following ports, clock and reset first:
- clk  in  1  the single clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous and active-high.
- push  in  1  write request.
- pop  in  1  read request; consumes the head entry.
- flush  in  1  synchronous clear of contents.
- clr_err  in  1  synchronous clear of sticky error flags.
- din  in  DATA_WIDTH  write data.
- dout  out  DATA_WIDTH  head entry, first-word-fall-through.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  $clog2(DEPTH)+1  number of stored entries.
- overflow  out  1  sticky flag: a push was rejected.
- underflow  out  1  sticky flag: a pop was rejected.

Function
REQ-006 Write and read pointers SHALL each be $clog2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0 with no extra logic.
REQ-007 count SHALL be a registered value; full, empty, almost_full and almost_empty SHALL be decoded combinationally from count.
REQ-008 A push SHALL be accepted when (push & ~full) or (push & pop & full); an accepted push writes din at wr_ptr and increments wr_ptr.
REQ-009 A pop SHALL be accepted when pop & ~empty; an accepted pop increments rd_ptr.
REQ-010 dout SHALL equal mem[rd_ptr] combinationally, so data is valid in the same cycle that empty is low (zero-cycle read latency).
REQ-011 Write-to-read latency SHALL be one cycle: data pushed at edge N is visible on dout and empty deasserts after edge N.
REQ-012 On each edge, count SHALL change by +1 for an accepted push only, by -1 for an accepted pop only, and by 0 when both or neither are accepted.
REQ-013 Push and pop on empty SHALL accept the push, reject the pop, and set underflow.
REQ-014 Push and pop on full SHALL accept both; count stays at DEPTH and overflow is not set.
REQ-015 Push on full without pop SHALL be rejected: memory and pointers unchanged, overflow set.
REQ-016 overflow and underflow SHALL remain set until clr_err or rst; if a new error and clr_err occur in the same cycle, the flag SHALL be set.
REQ-017 flush SHALL take priority over push and pop: on the next edge both pointers and count go to 0, and the push/pop in that cycle are ignored and not flagged; flush SHALL NOT clear the error flags.
REQ-018 Memory contents SHALL NOT be reset or flushed; only control state is.

Reset
REQ-019 Asserting rst SHALL immediately and asynchronously set the pointers, count, overflow and underflow to 0, including in the middle of an operation.
REQ-020 During and after reset the outputs SHALL read empty=1, full=0, count=0, almost_empty=1, and almost_full=(AFULL_TH==0).
REQ-021 No push or pop SHALL be accepted while rst is high; normal operation SHALL resume on the first rising edge after rst deasserts.

Structure
REQ-022 The shared package fifo_pkg SHALL hold the ptr_w/cnt_w width functions and the error-flag struct typedef.
REQ-023 Pointer, count and flag logic SHALL live in the sub-module fifo_ctrl; sync_fifo_param SHALL hold the storage array and instantiate fifo_ctrl.
REQ-024 The design SHALL contain elaboration-time assertions on DEPTH being a power of two, and on AFULL_TH <= DEPTH and AEMPTY_TH < DEPTH.

Verification (DEPTH=8, DATA_WIDTH=32)
REQ-025 Fill and drain: push 8 words 0x10..0x17, then pop 8 -> full=1 at count=8; dout follows 0x10..0x17 in order; empty=1 at the end; no error flags.
REQ-026 Wrap-around: push 5, pop 5, then push 8 -> the pointers wrap, full=1, and the 8 words read back in order.
REQ-027 Overflow and full bypass: at full, push alone -> overflow=1 and count=8; then push+pop of 0xAA -> count=8 and 0xAA is read out last; then clr_err -> overflow=0.
REQ-028 Underflow on empty: push+pop of 0x55 -> count=1, dout=0x55, underflow=1.
REQ-029 Thresholds and flush: push 6 -> almost_full=1; flush together with push -> count=0, empty=1, almost_empty=1, no flag change.
REQ-030 Async reset mid-stream: assert rst between edges with count=4 -> count=0 and empty=1 immediately, before the next edge.
